// File: rtl/control_suma.sv
// control_suma: keypad sequencer for a registered 12-bit + 12-bit adder.
// Builds two decimal operands digit by digit, presents them to the adder,
// waits out the adder latency, latches the sum and selects what to display.
module control_suma #(
    parameter int MAX_DIGITS  = 3,
    parameter int ADD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [11:0] num1,
    output logic [11:0] num2,
    input  logic [12:0] sum_in,
    output logic [12:0] result,
    output logic        result_vld,
    output logic [12:0] disp_val,
    output logic [1:0]  state_o,
    output logic [1:0]  digits_o
);

    typedef enum logic [1:0] {
        S_OP1  = 2'd0,
        S_OP2  = 2'd1,
        S_WAIT = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // Counter wide enough to hold ADD_LATENCY; at least one bit.
    localparam int CW = (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;
    localparam logic [CW-1:0] LAT_LOAD   = CW'(ADD_LATENCY);
    localparam logic [1:0]    MAX_DIG    = 2'(MAX_DIGITS);

    state_t        state_q;
    logic [11:0]   num1_q, num2_q;
    logic [12:0]   result_q;
    logic          result_vld_q;
    logic [1:0]    digits_q;
    logic [CW-1:0] cnt_q;

    // Key decode; all qualified by key_valid so idle cycles decode to nothing.
    logic is_digit, is_plus, is_eq, is_clr, room;
    logic [11:0] num1_d, num2_d;

    // Classify the key and precompute the decimal shift-in for each operand.
    always_comb begin
        is_digit = key_valid && (key_code <= 4'd9);
        is_plus  = key_valid && (key_code == 4'hA);
        is_eq    = key_valid && (key_code == 4'hB);
        is_clr   = key_valid && (key_code == 4'hC);
        room     = (digits_q < MAX_DIG);
        // The digit limit keeps these below 1000, so 12 bits never wrap.
        num1_d   = 12'(num1_q * 12'd10) + {8'd0, key_code};
        num2_d   = 12'(num2_q * 12'd10) + {8'd0, key_code};
    end

    // Sequencer: reset/clear, operand entry, latency wait and result hold.
    always_ff @(posedge clk) begin
        if (rst || is_clr) begin
            state_q      <= S_OP1;
            num1_q       <= '0;
            num2_q       <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            digits_q     <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_OP1: begin
                    if (is_digit && room) begin
                        num1_q   <= num1_d;
                        digits_q <= digits_q + 2'd1;
                    end else if (is_plus) begin
                        state_q  <= S_OP2;
                        digits_q <= '0;
                    end
                end
                S_OP2: begin
                    if (is_digit && room) begin
                        num2_q   <= num2_d;
                        digits_q <= digits_q + 2'd1;
                    end else if (is_eq) begin
                        state_q <= S_WAIT;
                        cnt_q   <= LAT_LOAD;
                    end
                end
                S_WAIT: begin
                    // Operands stay frozen here so the adder output settles.
                    if (cnt_q == '0) begin
                        result_q     <= sum_in;
                        result_vld_q <= 1'b1;
                        state_q      <= S_SHOW;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SHOW: begin
                    // A digit begins the next operation; result is kept for display history.
                    if (is_digit) begin
                        num1_q       <= {8'd0, key_code};
                        num2_q       <= '0;
                        digits_q     <= 2'd1;
                        result_vld_q <= 1'b0;
                        state_q      <= S_OP1;
                    end
                end
                default: state_q <= S_OP1;
            endcase
        end
    end

    // Display mux over registered values: operand being typed, or the sum.
    always_comb begin
        case (state_q)
            S_OP1:   disp_val = {1'b0, num1_q};
            S_SHOW:  disp_val = result_q;
            default: disp_val = {1'b0, num2_q};
        endcase
    end

    assign num1       = num1_q;
    assign num2       = num2_q;
    assign result     = result_q;
    assign result_vld = result_vld_q;
    assign state_o    = state_q;
    assign digits_o   = digits_q;

endmodule
